packet_decoder: RTL and testbench

Receive-side counterpart of the packet encoder. Consumes the framed byte stream (destination address, payload size, payload bytes, parity), filters on destination address, streams the payload out one byte per cycle, and reports parity and truncation errors at the end of each packet. Sits directly on the encoder's `packet_out`/`packet_valid` link at the far end of the channel.

---
 rtl/packet_decoder.sv | 80 ++++++++
 tb/tb_packet_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/packet_decoder.sv
// packet_decoder: framed byte-stream receiver with address filter, payload streaming and parity/truncation reporting
module packet_decoder #(
  parameter logic [7:0] MY_ADDR = 8'hAA,
  parameter logic [7:0] BCAST_ADDR = 8'hFF,
  parameter bit FILTER_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] packet_in,
  input  logic       packet_valid,
  output logic [7:0] dest_addr_out,
  output logic [7:0] payload_size_out,
  output logic [7:0] payload_dout,
  output logic       payload_valid,
  output logic       pkt_done,
  output logic       addr_match,
  output logic       parity_err,
  output logic       trunc_err,
  output logic       busy
);
  typedef enum logic [1:0] {ADDR, SIZE, PAYLOAD, PARITY} state_t;
  state_t state, state_nx;
  logic [7:0] xor_q, cnt;
  logic match_q, hit;
  always_comb begin
    hit = !FILTER_EN || packet_in == MY_ADDR || packet_in == BCAST_ADDR;
    state_nx = !packet_valid ? ADDR :
               state == ADDR ? SIZE :
               state == SIZE ? (packet_in == 8'd0 ? PARITY : PAYLOAD) :
               state == PAYLOAD ? (cnt == 8'd1 ? PARITY : PAYLOAD) : ADDR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ADDR;
      xor_q <= '0;
      cnt <= '0;
      match_q <= 1'b0;
      dest_addr_out <= '0;
      payload_size_out <= '0;
      payload_dout <= '0;
      payload_valid <= 1'b0;
      pkt_done <= 1'b0;
      addr_match <= 1'b0;
      parity_err <= 1'b0;
      trunc_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= state_nx != ADDR;
      payload_valid <= 1'b0;
      pkt_done <= 1'b0;
      trunc_err <= packet_valid ? 1'b0 : state != ADDR;
      if (packet_valid) begin
        case (state)
          ADDR: begin
            dest_addr_out <= packet_in;
            xor_q <= packet_in;
            match_q <= hit;
          end
          SIZE: begin
            payload_size_out <= packet_in;
            xor_q <= xor_q ^ packet_in;
            cnt <= packet_in;
          end
          PAYLOAD: begin
            xor_q <= xor_q ^ packet_in;
            cnt <= cnt - 8'd1;
            payload_valid <= match_q;
            payload_dout <= match_q ? packet_in : payload_dout;
          end
          default: begin
            pkt_done <= 1'b1;
            addr_match <= match_q;
            parity_err <= packet_in != xor_q;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_packet_decoder.sv
// tb_packet_decoder: table-driven and randomized self-checking bench for packet_decoder
module tb_packet_decoder;
  logic clk = 1'b0;
  logic rst, packet_valid;
  logic [7:0] packet_in;
  logic [7:0] dest0, size0, pd0, dest1, size1, pd1;
  logic pv0, done0, match0, perr0, trunc0, busy0;
  logic pv1, done1, match1, perr1, trunc1, busy1;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_pl0[$], got_pl0[$], exp_ev0[$], got_ev0[$];
  logic [7:0] exp_pl1[$], got_pl1[$], exp_ev1[$], got_ev1[$];
  typedef struct {
    bit v;
    logic [7:0] din;
    bit pv;
    logic [7:0] pd;
    bit done;
    bit match;
    bit perr;
    bit trunc;
    bit busy;
  } vec_t;
  vec_t tbl[$];

  packet_decoder u0 (
    .clk(clk), .rst(rst), .packet_in(packet_in), .packet_valid(packet_valid),
    .dest_addr_out(dest0), .payload_size_out(size0), .payload_dout(pd0),
    .payload_valid(pv0), .pkt_done(done0), .addr_match(match0),
    .parity_err(perr0), .trunc_err(trunc0), .busy(busy0)
  );

  packet_decoder #(.FILTER_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .packet_in(packet_in), .packet_valid(packet_valid),
    .dest_addr_out(dest1), .payload_size_out(size1), .payload_dout(pd1),
    .payload_valid(pv1), .pkt_done(done1), .addr_match(match1),
    .parity_err(perr1), .trunc_err(trunc1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pv0) got_pl0.push_back(pd0);
      if (done0) got_ev0.push_back({6'd0, match0, perr0});
      if (trunc0) got_ev0.push_back(8'h80);
      if (pv1) got_pl1.push_back(pd1);
      if (done1) got_ev1.push_back({6'd0, match1, perr1});
      if (trunc1) got_ev1.push_back(8'h80);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] b);
    rst = r;
    packet_valid = v;
    packet_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic cmpq(input string nm, input logic [7:0] g[$], input logic [7:0] e[$]);
    chk({nm, "_len"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++) chk(nm, g[i], e[i]);
  endtask

  function automatic void row(bit v, logic [7:0] din, bit pv, logic [7:0] pd,
                              bit done, bit m, bit pe, bit tr, bit bz);
    tbl.push_back('{v, din, pv, pd, done, m, pe, tr, bz});
  endfunction
  function automatic void hdr(logic [7:0] b);
    row(1, b, 0, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic void pl(logic [7:0] b);
    row(1, b, 1, b, 0, 0, 0, 0, 1);
  endfunction
  function automatic void par(logic [7:0] b, bit m, bit pe);
    row(1, b, 0, 0, 1, m, pe, 0, 0);
  endfunction

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] addr, n, x;
    bit acc, corrupt, trn;
    int k;
    hdr(8'hAA); hdr(8'h05); pl(8'h11); pl(8'h22); pl(8'h33); pl(8'h44); pl(8'h55); par(8'hBE, 1, 0);
    hdr(8'hAA); hdr(8'h05); pl(8'h11); pl(8'h22); pl(8'h33); pl(8'h44); pl(8'h55); par(8'hBF, 1, 1);
    hdr(8'hBB); hdr(8'h02); hdr(8'h01); hdr(8'h02); par(8'hBA, 0, 0);
    hdr(8'hFF); hdr(8'h01); pl(8'h7E); par(8'h80, 1, 0);
    hdr(8'hAA); hdr(8'h00); par(8'hAA, 1, 0);
    hdr(8'hAA); hdr(8'h03); pl(8'h01);
    row(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    row(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    hdr(8'hAA); hdr(8'h00); par(8'hAA, 1, 0);

    drive(1, 0, 8'h00);
    drive(1, 0, 8'h00);
    chk("rst_dest", dest0, 0); chk("rst_size", size0, 0); chk("rst_pd", pd0, 0);
    chk("rst_pv", pv0, 0); chk("rst_done", done0, 0); chk("rst_match", match0, 0);
    chk("rst_perr", perr0, 0); chk("rst_trunc", trunc0, 0); chk("rst_busy", busy0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(0, tbl[i].v, tbl[i].din);
      chk($sformatf("v%0d_pv", i), pv0, tbl[i].pv);
      if (tbl[i].pv) chk($sformatf("v%0d_pd", i), pd0, tbl[i].pd);
      chk($sformatf("v%0d_done", i), done0, tbl[i].done);
      if (tbl[i].done) begin
        chk($sformatf("v%0d_match", i), match0, tbl[i].match);
        chk($sformatf("v%0d_perr", i), perr0, tbl[i].perr);
      end
      chk($sformatf("v%0d_trunc", i), trunc0, tbl[i].trunc);
      chk($sformatf("v%0d_busy", i), busy0, tbl[i].busy);
      if (i == 7) begin
        chk("nom_dest", dest0, 8'hAA);
        chk("nom_size", size0, 8'h05);
      end
      if (i == 18 || i == 19) begin
        chk($sformatf("nofilt%0d_pv", i), pv1, 1);
        chk($sformatf("nofilt%0d_pd", i), pd1, tbl[i].din);
      end
      if (i == 20) chk("nofilt_match", match1, 1);
    end

    drive(0, 1, 8'hAA); drive(0, 1, 8'h05); drive(0, 1, 8'h11);
    drive(1, 1, 8'h22);
    chk("mrst_dest", dest0, 0); chk("mrst_size", size0, 0); chk("mrst_pd", pd0, 0);
    chk("mrst_pv", pv0, 0); chk("mrst_done", done0, 0); chk("mrst_trunc", trunc0, 0);
    chk("mrst_busy", busy0, 0);
    drive(0, 0, 8'h00);
    chk("mrst_notrunc", trunc0, 0);
    drive(0, 1, 8'hAA); drive(0, 1, 8'h01);
    drive(0, 1, 8'h10);
    chk("mrst_pv", pv0, 1); chk("mrst_pd10", pd0, 8'h10);
    drive(0, 1, 8'hBB);
    chk("mrst_done", done0, 1); chk("mrst_perr", perr0, 0); chk("mrst_m", match0, 1);
    drive(0, 0, 8'h00);

    mon_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 3))
        0: addr = 8'hAA;
        1: addr = 8'hFF;
        default: addr = 8'($urandom);
      endcase
      n = (p == 30) ? 8'd255 : 8'($urandom_range(0, 12));
      acc = addr == 8'hAA || addr == 8'hFF;
      corrupt = $urandom_range(0, 3) == 0;
      pkt.delete();
      pkt.push_back(addr);
      pkt.push_back(n);
      x = addr ^ n;
      for (int j = 0; j < n; j++) begin
        pkt.push_back(8'($urandom));
        x ^= pkt[pkt.size() - 1];
      end
      pkt.push_back(corrupt ? x ^ 8'($urandom_range(1, 255)) : x);
      trn = $urandom_range(0, 5) == 0;
      k = trn ? $urandom_range(1, pkt.size() - 1) : pkt.size();
      for (int j = 0; j < k; j++) begin
        drive(0, 1, pkt[j]);
        if (j >= 2 && j < n + 2) begin
          if (acc) exp_pl0.push_back(pkt[j]);
          exp_pl1.push_back(pkt[j]);
        end
      end
      if (trn) begin
        exp_ev0.push_back(8'h80);
        exp_ev1.push_back(8'h80);
        drive(0, 0, 8'($urandom));
      end else begin
        exp_ev0.push_back({6'd0, acc, corrupt});
        exp_ev1.push_back({6'd0, 1'b1, corrupt});
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) drive(0, 0, 8'($urandom));
    end
    drive(0, 0, 8'h00); drive(0, 0, 8'h00); drive(0, 0, 8'h00);
    mon_en = 1'b0;
    cmpq("rnd_payload_f1", got_pl0, exp_pl0);
    cmpq("rnd_events_f1", got_ev0, exp_ev0);
    cmpq("rnd_payload_f0", got_pl1, exp_pl1);
    cmpq("rnd_events_f0", got_ev1, exp_ev1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
